clint_ctrl: RTL and testbench

- Core-local interrupt/trap controller. Sits directly upstream of the CSR register file and drives its clint_* write port.
- Detects ecall/ebreak/mret from the ID-stage instruction, plus external/timer interrupt requests.
- Sequences the mepc/mstatus/mcause CSR writes over successive cycles while holding the pipeline.
- Issues a one-cycle redirect to the trap handler (mtvec) or the return address (mepc).

---
 rtl/clint_ctrl.sv | 149 ++++++++++++++
 tb/tb_clint_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clint_ctrl.sv
// Core-local interrupt/trap controller: sequences mepc/mstatus/mcause writes and redirects the pipeline.
// Optional build macro CLINT_VECTORED_EN enables vectored redirect for asynchronous traps.
module clint_ctrl #(
   parameter logic [63:0] INT_CAUSE    = 64'h8000_0000_0000_0007,
   parameter logic [63:0] ECALL_CAUSE  = 64'd11,
   parameter logic [63:0] EBREAK_CAUSE = 64'd3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] inst_i,
   input  logic [63:0] inst_addr_i,
   input  logic        jump_flag_i,
   input  logic [63:0] jump_addr_i,
   input  logic [7:0]  int_flag_i,
   input  logic [63:0] csr_mtvec_i,
   input  logic [63:0] csr_mepc_i,
   input  logic [63:0] csr_mstatus_i,
   input  logic        global_int_en_i,
   output logic        clint_we_o,
   output logic [63:0] clint_waddr_o,
   output logic [63:0] clint_data_o,
   output logic        hold_flag_o,
   output logic        int_assert_o,
   output logic [63:0] int_addr_o
);

   localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
   localparam logic [31:0] INST_MRET   = 32'h3020_0073;
   localparam logic [63:0] ADDR_MSTATUS = 64'h300;
   localparam logic [63:0] ADDR_MEPC    = 64'h341;
   localparam logic [63:0] ADDR_MCAUSE  = 64'h342;

   typedef enum logic [2:0] {
      S_IDLE, S_MEPC, S_MSTATUS, S_MCAUSE, S_ASSERT, S_MRET_ST, S_MRET_AS
   } state_t;

   state_t      state;
   logic [63:0] cause_q;
   logic        is_ecall, is_ebreak, is_mret, is_sync, is_async, req;
   logic [63:0] trap_mstatus, mret_mstatus, async_pc, trap_target;

   assign is_ecall  = (inst_i == INST_ECALL);
   assign is_ebreak = (inst_i == INST_EBREAK);
   assign is_mret   = (inst_i == INST_MRET);
   assign is_sync   = is_ecall | is_ebreak;
   assign is_async  = (|int_flag_i) & global_int_en_i;
   assign req       = is_sync | is_mret | is_async;

   // Interrupts taken while EX redirects must return to the redirect target.
   assign async_pc = jump_flag_i ? jump_addr_i : inst_addr_i;

   always_comb begin
      trap_mstatus    = csr_mstatus_i;
      trap_mstatus[7] = csr_mstatus_i[3];
      trap_mstatus[3] = 1'b0;
      mret_mstatus    = csr_mstatus_i;
      mret_mstatus[3] = csr_mstatus_i[7];
      mret_mstatus[7] = 1'b1;
   end

`ifdef CLINT_VECTORED_EN
   logic async_q;

   always_comb begin
      trap_target = {csr_mtvec_i[63:2], 2'b00};
      if (async_q && csr_mtvec_i[1:0] == 2'b01)
         trap_target = {csr_mtvec_i[63:2], 2'b00} + {cause_q[61:0], 2'b00};
   end
`else
   assign trap_target = csr_mtvec_i;
`endif

   // Hold asserts combinationally in the detection cycle, then follows the FSM.
   assign hold_flag_o = rst_n & ((state != S_IDLE) | req);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         cause_q       <= '0;
         clint_we_o    <= 1'b0;
         clint_waddr_o <= '0;
         clint_data_o  <= '0;
         int_assert_o  <= 1'b0;
         int_addr_o    <= '0;
`ifdef CLINT_VECTORED_EN
         async_q       <= 1'b0;
`endif
      end else begin
         clint_we_o    <= 1'b0;
         clint_waddr_o <= '0;
         clint_data_o  <= '0;
         int_assert_o  <= 1'b0;
         int_addr_o    <= '0;
         case (state)
            S_IDLE: begin
               if (is_sync) begin
                  state         <= S_MEPC;
                  cause_q       <= is_ecall ? ECALL_CAUSE : EBREAK_CAUSE;
                  clint_we_o    <= 1'b1;
                  clint_waddr_o <= ADDR_MEPC;
                  clint_data_o  <= inst_addr_i;
`ifdef CLINT_VECTORED_EN
                  async_q       <= 1'b0;
`endif
               end else if (is_mret) begin
                  state         <= S_MRET_ST;
                  clint_we_o    <= 1'b1;
                  clint_waddr_o <= ADDR_MSTATUS;
                  clint_data_o  <= mret_mstatus;
               end else if (is_async) begin
                  state         <= S_MEPC;
                  cause_q       <= INT_CAUSE;
                  clint_we_o    <= 1'b1;
                  clint_waddr_o <= ADDR_MEPC;
                  clint_data_o  <= async_pc;
`ifdef CLINT_VECTORED_EN
                  async_q       <= 1'b1;
`endif
               end
            end
            S_MEPC: begin
               state         <= S_MSTATUS;
               clint_we_o    <= 1'b1;
               clint_waddr_o <= ADDR_MSTATUS;
               clint_data_o  <= trap_mstatus;
            end
            S_MSTATUS: begin
               state         <= S_MCAUSE;
               clint_we_o    <= 1'b1;
               clint_waddr_o <= ADDR_MCAUSE;
               clint_data_o  <= cause_q;
            end
            S_MCAUSE: begin
               state        <= S_ASSERT;
               int_assert_o <= 1'b1;
               int_addr_o   <= trap_target;
            end
            S_MRET_ST: begin
               state        <= S_MRET_AS;
               int_assert_o <= 1'b1;
               int_addr_o   <= csr_mepc_i;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_clint_ctrl.sv
// Self-checking bench for clint_ctrl: a CSR-file stand-in plus a trace-level reference model.
module tb_clint_ctrl;

   localparam int W = 195;
   localparam logic [31:0] ECALL  = 32'h0000_0073;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] MRET   = 32'h3020_0073;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] inst_i = NOP;
   logic [63:0] inst_addr_i = '0;
   logic        jump_flag_i = 1'b0;
   logic [63:0] jump_addr_i = '0;
   logic [7:0]  int_flag_i = '0;
   logic        global_int_en_i;
   logic        clint_we_o, hold_flag_o, int_assert_o;
   logic [63:0] clint_waddr_o, clint_data_o, int_addr_o;

   logic [63:0] env_mtvec = '0, env_mepc = '0, env_mstatus = '0, env_mcause = '0;
   logic [63:0] ld_mtvec = '0, ld_mepc = '0, ld_mstatus = '0;
   logic        ld_en = 1'b0;

   logic [63:0] mdl_mtvec = '0, mdl_mepc = '0, mdl_mstatus = '0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] obs_v, exp_v, o;
   int checks = 0;
   int errors = 0;

   assign global_int_en_i = env_mstatus[3];
   assign obs_v = {hold_flag_o, clint_we_o, clint_waddr_o, clint_data_o, int_assert_o, int_addr_o};

   clint_ctrl dut (
      .clk(clk), .rst_n(rst_n), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
      .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i), .int_flag_i(int_flag_i),
      .csr_mtvec_i(env_mtvec), .csr_mepc_i(env_mepc), .csr_mstatus_i(env_mstatus),
      .global_int_en_i(global_int_en_i), .clint_we_o(clint_we_o), .clint_waddr_o(clint_waddr_o),
      .clint_data_o(clint_data_o), .hold_flag_o(hold_flag_o), .int_assert_o(int_assert_o),
      .int_addr_o(int_addr_o)
   );

   always #5 clk = ~clk;

   // CSR file stand-in: accepts the controller's writes, or a bench preload.
   always @(posedge clk) begin
      if (ld_en) begin
         env_mtvec   <= ld_mtvec;
         env_mepc    <= ld_mepc;
         env_mstatus <= ld_mstatus;
      end else if (clint_we_o) begin
         case (clint_waddr_o)
            64'h341: env_mepc    <= clint_data_o;
            64'h300: env_mstatus <= clint_data_o;
            64'h342: env_mcause  <= clint_data_o;
            default: ;
         endcase
      end
   end

   function automatic logic [W-1:0] pk(input logic h, input logic we, input logic [63:0] a,
                                       input logic [63:0] d, input logic as, input logic [63:0] ia);
      return {h, we, a, d, as, ia};
   endfunction

   // Reference model: expected per-cycle trace for the request presented in an idle cycle.
   function automatic void model_req(input logic [31:0] inst, input logic [63:0] pc, input logic jf,
                                     input logic [63:0] ja, input logic [7:0] intf);
      logic [63:0] cause, retpc, ms, base, tgt;
      bit          async_trap, trap;
      trap = 1'b0; async_trap = 1'b0; cause = '0; retpc = pc;
      if (inst == ECALL || inst == EBREAK) begin
         trap = 1'b1; cause = (inst == ECALL) ? 64'd11 : 64'd3;
      end else if (inst == MRET) begin
         ms = (mdl_mstatus & ~64'h8) | (((mdl_mstatus >> 7) & 64'd1) << 3) | 64'h80;
         exp_q.push_back(pk(1, 0, 0, 0, 0, 0));
         exp_q.push_back(pk(1, 1, 64'h300, ms, 0, 0));
         exp_q.push_back(pk(1, 0, 0, 0, 1, mdl_mepc));
         mdl_mstatus = ms;
         return;
      end else if (intf != 0 && mdl_mstatus[3]) begin
         trap = 1'b1; async_trap = 1'b1; cause = 64'h8000_0000_0000_0007;
         retpc = jf ? ja : pc;
      end
      if (!trap) begin
         exp_q.push_back(pk(0, 0, 0, 0, 0, 0));
         return;
      end
      ms = (mdl_mstatus & ~64'h88) | (((mdl_mstatus >> 3) & 64'd1) << 7);
      base = mdl_mtvec - (mdl_mtvec % 4);
`ifdef CLINT_VECTORED_EN
      tgt = (async_trap && (mdl_mtvec % 4) == 1) ? base + cause * 4 : base;
`else
      tgt = mdl_mtvec;
      if (async_trap) tgt = tgt + base - base;
`endif
      exp_q.push_back(pk(1, 0, 0, 0, 0, 0));
      exp_q.push_back(pk(1, 1, 64'h341, retpc, 0, 0));
      exp_q.push_back(pk(1, 1, 64'h300, ms, 0, 0));
      exp_q.push_back(pk(1, 1, 64'h342, cause, 0, 0));
      exp_q.push_back(pk(1, 0, 0, 0, 1, tgt));
      mdl_mepc = retpc;
      mdl_mstatus = ms;
   endfunction

   task automatic drive(input logic [31:0] inst, input logic [63:0] pc, input logic jf,
                        input logic [63:0] ja, input logic [7:0] intf);
      inst_i = inst; inst_addr_i = pc; jump_flag_i = jf; jump_addr_i = ja; int_flag_i = intf;
   endtask

   // One cycle: drive at the falling edge, sample 1 ns later.
   task automatic step(input logic [31:0] inst, input logic [63:0] pc, input logic jf,
                       input logic [63:0] ja, input logic [7:0] intf, output logic [W-1:0] ob);
      @(negedge clk);
      drive(inst, pc, jf, ja, intf);
      #1;
      ob = obs_v;
   endtask

   task automatic set_csr(input logic [63:0] mtvec, input logic [63:0] mepc, input logic [63:0] mstatus);
      @(negedge clk);
      drive(NOP, 64'h0, 1'b0, 64'h0, 8'h0);
      ld_mtvec = mtvec; ld_mepc = mepc; ld_mstatus = mstatus; ld_en = 1'b1;
      @(negedge clk);
      ld_en = 1'b0;
      mdl_mtvec = mtvec; mdl_mepc = mepc; mdl_mstatus = mstatus;
   endtask

   task automatic test_reset();
      drive(ECALL, 64'h40, 1'b0, 64'h0, 8'hff);
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (obs_v !== '0) begin
         errors++; $display("FAIL reset_outputs got %h exp 0", obs_v);
      end
      drive(NOP, 64'h0, 1'b0, 64'h0, 8'h0);
      rst_n = 1'b1;
      step(NOP, 64'h0, 1'b0, 64'h0, 8'h0, o);
      checks++;
      if (o !== '0) begin
         errors++; $display("FAIL reset_idle got %h exp 0", o);
      end
   endtask

   task automatic test_ecall();
      int hold_cycles = 0;
      set_csr(64'h800, 64'h0, 64'h8);
      model_req(ECALL, 64'h100, 1'b0, 64'h0, 8'h0);
      for (int n = 0; exp_q.size() != 0; n++) begin
         if (n == 0) step(ECALL, 64'h100, 1'b0, 64'h0, 8'h0, o);
         else        step(NOP, 64'h104, 1'b0, 64'h0, 8'h0, o);
         exp_v = exp_q.pop_front();
         hold_cycles += int'(hold_flag_o);
         checks++;
         if (o !== exp_v) begin
            errors++; $display("FAIL ecall cyc %0d got %h exp %h", n, o, exp_v);
         end
      end
      checks++;
      if (hold_cycles != 5) begin
         errors++; $display("FAIL ecall_hold_len got %0d exp 5", hold_cycles);
      end
   endtask

   task automatic test_async();
      set_csr(64'h800, 64'h0, 64'h8);
      model_req(NOP, 64'h200, 1'b1, 64'h240, 8'h01);
      for (int n = 0; exp_q.size() != 0; n++) begin
         if (n == 0) step(NOP, 64'h200, 1'b1, 64'h240, 8'h01, o);
         else        step(NOP, 64'h204, 1'b0, 64'h0, 8'h00, o);
         exp_v = exp_q.pop_front();
         checks++;
         if (o !== exp_v) begin
            errors++; $display("FAIL async cyc %0d got %h exp %h", n, o, exp_v);
         end
      end
   endtask

   task automatic test_async_masked();
      for (int n = 0; n < 3; n++) model_req(NOP, 64'h200, 1'b1, 64'h240, 8'h01);
      for (int n = 0; exp_q.size() != 0; n++) begin
         step(NOP, 64'h200, 1'b1, 64'h240, 8'h01, o);
         exp_v = exp_q.pop_front();
         checks++;
         if (o !== exp_v) begin
            errors++; $display("FAIL async_masked cyc %0d got %h exp %h", n, o, exp_v);
         end
      end
   endtask

   task automatic test_mret();
      set_csr(64'h800, 64'h104, 64'h80);
      model_req(MRET, 64'h300, 1'b0, 64'h0, 8'h0);
      model_req(NOP, 64'h104, 1'b0, 64'h0, 8'h0);
      for (int n = 0; exp_q.size() != 0; n++) begin
         if (n == 0) step(MRET, 64'h300, 1'b0, 64'h0, 8'h0, o);
         else        step(NOP, 64'h104, 1'b0, 64'h0, 8'h0, o);
         exp_v = exp_q.pop_front();
         checks++;
         if (o !== exp_v) begin
            errors++; $display("FAIL mret cyc %0d got %h exp %h", n, o, exp_v);
         end
      end
   endtask

   task automatic test_priority();
      set_csr(64'h800, 64'h0, 64'h8);
      model_req(ECALL, 64'h180, 1'b0, 64'h0, 8'h01);
      for (int n = 0; n < 3; n++) model_req(NOP, 64'h800, 1'b0, 64'h0, 8'h01);
      for (int n = 0; exp_q.size() != 0; n++) begin
         if (n == 0) step(ECALL, 64'h180, 1'b0, 64'h0, 8'h01, o);
         else        step(NOP, 64'h800, 1'b0, 64'h0, 8'h01, o);
         exp_v = exp_q.pop_front();
         checks++;
         if (o !== exp_v) begin
            errors++; $display("FAIL priority cyc %0d got %h exp %h", n, o, exp_v);
         end
      end
   endtask

   task automatic test_midseq_reset();
      set_csr(64'h800, 64'h0, 64'h8);
      step(ECALL, 64'h500, 1'b0, 64'h0, 8'h0, o);
      step(NOP, 64'h504, 1'b0, 64'h0, 8'h0, o);
      step(NOP, 64'h504, 1'b0, 64'h0, 8'h0, o);
      checks++;
      if (o !== pk(1, 1, 64'h300, 64'h80, 0, 0)) begin
         errors++; $display("FAIL midrst_pre got %h exp mstatus write 0x80", o);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (obs_v !== '0) begin
         errors++; $display("FAIL midrst_async got %h exp 0", obs_v);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step(NOP, 64'h504, 1'b0, 64'h0, 8'h0, o);
      checks++;
      if (o !== '0) begin
         errors++; $display("FAIL midrst_idle got %h exp 0", o);
      end
      checks++;
      if (env_mepc !== 64'h500 || env_mstatus !== 64'h8) begin
         errors++; $display("FAIL midrst_partial mepc %h mstatus %h exp 500 8", env_mepc, env_mstatus);
      end
      mdl_mepc = 64'h500;
      mdl_mstatus = 64'h8;
   endtask

`ifdef CLINT_VECTORED_EN
   task automatic test_vectored();
      set_csr(64'h801, 64'h0, 64'h8);
      model_req(NOP, 64'h600, 1'b0, 64'h0, 8'h02);
      for (int n = 0; exp_q.size() != 0; n++) begin
         if (n == 0) step(NOP, 64'h600, 1'b0, 64'h0, 8'h02, o);
         else        step(NOP, 64'h604, 1'b0, 64'h0, 8'h00, o);
         exp_v = exp_q.pop_front();
         checks++;
         if (o !== exp_v) begin
            errors++; $display("FAIL vectored cyc %0d got %h exp %h", n, o, exp_v);
         end
      end
      checks++;
      if (int_addr_o !== 64'h81C) begin
         errors++; $display("FAIL vectored_addr got %h exp 81c", int_addr_o);
      end
   endtask
`endif

   task automatic test_back_to_back();
      logic [31:0] inst;
      logic [63:0] pc, ja;
      logic        jf;
      logic [7:0]  intf;
      for (int it = 0; it < 60; it++) begin
         if (it % 10 == 0)
            set_csr({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
         case ($urandom_range(0, 4))
            0: inst = ECALL;
            1: inst = EBREAK;
            2: inst = MRET;
            3: inst = $urandom;
            default: inst = NOP;
         endcase
         pc = {32'h0, $urandom} & ~64'h3;
         ja = {32'h0, $urandom} & ~64'h3;
         jf = 1'($urandom_range(0, 1));
         intf = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h0;
         model_req(inst, pc, jf, ja, intf);
         for (int n = 0; exp_q.size() != 0; n++) begin
            if (n == 0) step(inst, pc, jf, ja, intf, o);
            else        step($urandom, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                             {$urandom, $urandom}, 8'($urandom), o);
            exp_v = exp_q.pop_front();
            checks++;
            if (o !== exp_v) begin
               errors++; $display("FAIL random it %0d cyc %0d got %h exp %h", it, n, o, exp_v);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_ecall();
      test_async();
      test_async_masked();
      test_mret();
      test_priority();
      test_midseq_reset();
`ifdef CLINT_VECTORED_EN
      test_vectored();
`endif
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
